// File: rtl/kp_scan.sv
// 4x6 matrix keypad scanner: walks one active-low row at a time, debounces a
// single-key press and release, and pulses newkey once per accepted key.
module kp_scan #(
  parameter int SCAN_TICKS = 1000,
  parameter int DB_TICKS   = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] kpcol,
  output logic [3:0] kprow,
  output logic       newkey,
  output logic [4:0] keycode
);

  localparam int MAX_TICKS = (SCAN_TICKS > DB_TICKS) ? SCAN_TICKS : DB_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_TICKS - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD
  } state_e;

  state_e        state_q, state_d;
  logic [5:0]    sync1_q, sync1_d;
  logic [5:0]    scol_q, scol_d;
  logic [1:0]    row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    pat_q, pat_d;
  logic [4:0]    keycode_q, keycode_d;
  logic          newkey_q, newkey_d;

  // Exactly one column line pulled low means exactly one key on this row.
  function automatic logic single_low(input logic [5:0] cols);
    return $onehot(~cols);
  endfunction

  function automatic logic [2:0] low_index(input logic [5:0] cols);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (!cols[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_SCAN;
      sync1_q   <= '1;
      scol_q    <= '1;
      row_q     <= 2'd0;
      cnt_q     <= '0;
      pat_q     <= '1;
      keycode_q <= 5'd0;
      newkey_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values of the others.
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      scol_q    <= scol_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      keycode_q <= keycode_d;
      newkey_q  <= newkey_d;
    end
  end

  always_comb begin
    // NOTE: hold-value defaults first so no branch can infer a latch.
    state_d   = state_q;
    sync1_d   = kpcol;
    scol_d    = sync1_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    keycode_d = keycode_q;
    newkey_d  = 1'b0;

    unique case (state_q)
      ST_SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (single_low(scol_q)) begin
            pat_d   = scol_q;
            state_d = ST_DEBOUNCE;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DEBOUNCE: begin
        if (scol_q == pat_q) begin
          if (cnt_q == DB_LAST) begin
            keycode_d = {row_q, low_index(pat_q)};
            newkey_d  = 1'b1;
            cnt_d     = '0;
            state_d   = ST_HELD;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d   = '0;
          row_d   = row_q + 2'd1;
          state_d = ST_SCAN;
        end
      end

      ST_HELD: begin
        // Any bounce low restarts the release run.
        if (scol_q == 6'b111111) begin
          if (cnt_q == DB_LAST) begin
            cnt_d   = '0;
            row_d   = row_q + 2'd1;
            state_d = ST_SCAN;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = '0;
        end
      end

      default: begin
        state_d = ST_SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    kprow   = ~(4'b0001 << row_q);
    newkey  = newkey_q;
    keycode = keycode_q;
  end

endmodule

// File: tb/tb_kp_scan.sv
// Bench for kp_scan: emulates a 4x6 switch matrix, checks every cycle against a
// behavioural model, then checks directed press/bounce/reset scenarios.
module tb_kp_scan;

  localparam int ST = 4;
  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] kpcol = 6'b111111;
  logic [3:0] kprow;
  logic       newkey;
  logic [4:0] keycode;

  kp_scan #(.SCAN_TICKS(ST), .DB_TICKS(DB)) dut (
    .clk    (clk),
    .rst    (rst),
    .kpcol  (kpcol),
    .kprow  (kprow),
    .newkey (newkey),
    .keycode(keycode)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int dut_pulses = 0;

  // press[r][c] = 1 means the switch at row r, column c is closed
  logic [5:0] press [4];

  // Behavioural model: which row is lit, how long it has dwelt there, and the
  // length of the current matching (debounce) or all-open (release) run.
  typedef enum {M_SCAN, M_DEBOUNCE, M_HELD} mphase_e;
  mphase_e    m_phase;
  int         m_row, m_dwell, m_run;
  logic [5:0] m_pat;
  logic [5:0] m_pipe [2];
  logic [4:0] m_key;
  bit         m_pulse;

  function automatic int low_count(input logic [5:0] c);
    int n;
    n = 0;
    for (int i = 0; i < 6; i++) if (!c[i]) n++;
    return n;
  endfunction

  function automatic int low_col(input logic [5:0] c);
    int k;
    k = 0;
    for (int i = 0; i < 6; i++) if (!c[i]) k = i;
    return k;
  endfunction

  task automatic model_step();
    logic [5:0] scol;
    if (rst) begin
      m_phase  = M_SCAN;
      m_row    = 0;
      m_dwell  = 0;
      m_run    = 0;
      m_pat    = 6'b111111;
      m_pipe[0] = 6'b111111;
      m_pipe[1] = 6'b111111;
      m_key    = 5'd0;
      m_pulse  = 1'b0;
    end else begin
      scol      = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = kpcol;
      m_pulse   = 1'b0;
      case (m_phase)
        M_SCAN: begin
          m_dwell++;
          if (m_dwell == ST) begin
            m_dwell = 0;
            if (low_count(scol) == 1) begin
              m_pat   = scol;
              m_run   = 0;
              m_phase = M_DEBOUNCE;
            end else begin
              m_row = (m_row + 1) % 4;
            end
          end
        end
        M_DEBOUNCE: begin
          if (scol == m_pat) begin
            m_run++;
            if (m_run == DB) begin
              m_key   = 5'(m_row * 8 + low_col(m_pat));
              m_pulse = 1'b1;
              m_run   = 0;
              m_phase = M_HELD;
            end
          end else begin
            m_row   = (m_row + 1) % 4;
            m_dwell = 0;
            m_phase = M_SCAN;
          end
        end
        default: begin
          if (scol == 6'b111111) begin
            m_run++;
            if (m_run == DB) begin
              m_run   = 0;
              m_dwell = 0;
              m_row   = (m_row + 1) % 4;
              m_phase = M_SCAN;
            end
          end else begin
            m_run = 0;
          end
        end
      endcase
    end
  endtask

  task automatic drive_cols();
    logic [5:0] c;
    c = 6'b111111;
    case (kprow)
      4'b1110: c = ~press[0];
      4'b1101: c = ~press[1];
      4'b1011: c = ~press[2];
      4'b0111: c = ~press[3];
      default: c = 6'b111111;
    endcase
    kpcol = c;
  endtask

  // One clock: present the matrix, advance model and DUT, compare outputs.
  task automatic tick();
    logic [3:0] exp_row;
    drive_cols();
    @(posedge clk);
    model_step();
    #1;
    exp_row = ~(4'b0001 << m_row);
    checks++;
    if (kprow !== exp_row) begin
      errors++;
      $display("FAIL model_kprow: got %b expected %b at %0t", kprow, exp_row, $time);
    end
    checks++;
    if (newkey !== m_pulse) begin
      errors++;
      $display("FAIL model_newkey: got %b expected %b at %0t", newkey, m_pulse, $time);
    end
    checks++;
    if (keycode !== m_key) begin
      errors++;
      $display("FAIL model_keycode: got %b expected %b at %0t", keycode, m_key, $time);
    end
    if (newkey === 1'b1) dut_pulses++;
  endtask

  task automatic release_all();
    for (int i = 0; i < 4; i++) press[i] = 6'b000000;
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    release_all();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (kprow !== 4'b1110 || newkey !== 1'b0 || keycode !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: got kprow=%b newkey=%b keycode=%b expected 1110 0 00000",
               kprow, newkey, keycode);
    end
    rst = 1'b0;
    dut_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) tick();
      exp_row = ~(4'b0001 << ((i / 4) % 4));
      checks++;
      if (kprow !== exp_row) begin
        errors++;
        $display("FAIL idle_row_seq[%0d]: got %b expected %b", i, kprow, exp_row);
      end
    end
    checks++;
    if (dut_pulses != 0 || keycode !== 5'd0) begin
      errors++;
      $display("FAIL idle_no_key: got pulses=%0d keycode=%b expected 0 00000", dut_pulses, keycode);
    end
  endtask

  task automatic test_single_key();
    int held;
    dut_pulses = 0;
    press[2] = 6'b001000;
    repeat (40) tick();
    checks++;
    if (dut_pulses != 1) begin
      errors++;
      $display("FAIL single_key_pulses: got %0d expected 1", dut_pulses);
    end
    checks++;
    if (keycode !== 5'b10011) begin
      errors++;
      $display("FAIL single_key_code: got %b expected 10011", keycode);
    end
    release_all();
    held = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (kprow !== 4'b1011) break;
      held++;
    end
    // two synchronizer cycles plus DB clean cycles, minus the edge that leaves
    checks++;
    if (held != 2 + DB - 1) begin
      errors++;
      $display("FAIL single_key_release: got %0d held cycles expected %0d", held, 2 + DB - 1);
    end
    checks++;
    if (dut_pulses != 1) begin
      errors++;
      $display("FAIL single_key_after_release: got %0d pulses expected 1", dut_pulses);
    end
  endtask

  task automatic test_glitch();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_phase == M_SCAN && m_row == 0 && m_dwell == 0) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL glitch_align: got timeout expected row 0 start within 40 cycles");
    end
    dut_pulses = 0;
    press[0] = 6'b000001;
    repeat (5) tick();
    release_all();
    repeat (3) tick();
    checks++;
    if (kprow !== 4'b1101) begin
      errors++;
      $display("FAIL glitch_resume_row: got %b expected 1101", kprow);
    end
    repeat (20) tick();
    checks++;
    if (dut_pulses != 0) begin
      errors++;
      $display("FAIL glitch_pulses: got %0d expected 0", dut_pulses);
    end
  endtask

  task automatic test_two_columns();
    logic [3:0] seen;
    seen = 4'b0000;
    dut_pulses = 0;
    press[1] = 6'b000011;
    for (int i = 0; i < 40; i++) begin
      tick();
      for (int r = 0; r < 4; r++) if (kprow === ~(4'b0001 << r)) seen[r] = 1'b1;
    end
    release_all();
    checks++;
    if (dut_pulses != 0) begin
      errors++;
      $display("FAIL two_col_pulses: got %0d expected 0", dut_pulses);
    end
    checks++;
    if (seen !== 4'b1111) begin
      errors++;
      $display("FAIL two_col_rows_seen: got %b expected 1111", seen);
    end
  endtask

  task automatic test_release_bounce();
    bit found;
    int held;
    bit stuck;
    dut_pulses = 0;
    found = 1'b0;
    press[3] = 6'b100000;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (newkey === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL bounce_accept: got timeout expected newkey within 60 cycles");
    end
    repeat (10) tick();
    stuck = 1'b1;
    release_all();
    repeat (3) begin tick(); if (kprow !== 4'b0111) stuck = 1'b0; end
    press[3] = 6'b100000;
    tick();
    if (kprow !== 4'b0111) stuck = 1'b0;
    release_all();
    checks++;
    if (!stuck) begin
      errors++;
      $display("FAIL bounce_row_held: got row change expected 0111 throughout bounce");
    end
    held = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (kprow !== 4'b0111) break;
      held++;
    end
    checks++;
    if (held != 2 + DB - 1) begin
      errors++;
      $display("FAIL bounce_release_run: got %0d held cycles expected %0d", held, 2 + DB - 1);
    end
    checks++;
    if (dut_pulses != 1 || keycode !== 5'b11101) begin
      errors++;
      $display("FAIL bounce_single_pulse: got pulses=%0d keycode=%b expected 1 11101",
               dut_pulses, keycode);
    end
  endtask

  task automatic test_reset_in_debounce();
    bit found;
    dut_pulses = 0;
    found = 1'b0;
    press[1] = 6'b000100;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (m_phase == M_DEBOUNCE) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rst_db_enter: got timeout expected debounce within 40 cycles");
    end
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (kprow !== 4'b1110 || newkey !== 1'b0 || keycode !== 5'd0) begin
      errors++;
      $display("FAIL rst_db_state: got kprow=%b newkey=%b keycode=%b expected 1110 0 00000",
               kprow, newkey, keycode);
    end
    checks++;
    if (dut_pulses != 0) begin
      errors++;
      $display("FAIL rst_db_abandon: got %0d pulses expected 0", dut_pulses);
    end
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (newkey === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || dut_pulses != 1 || keycode !== 5'b01010) begin
      errors++;
      $display("FAIL rst_db_redetect: got found=%0d pulses=%0d keycode=%b expected 1 1 01010",
               found, dut_pulses, keycode);
    end
    release_all();
    repeat (20) tick();
  endtask

  task automatic test_random();
    int r, c, len, gap;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      r   = $urandom_range(0, 3);
      c   = $urandom_range(0, 5);
      len = $urandom_range(1, 40);
      gap = $urandom_range(1, 30);
      press[r][c] = 1'b1;
      if ($urandom_range(0, 4) == 0) press[$urandom_range(0, 3)][$urandom_range(0, 5)] = 1'b1;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 15) == 0) press[r][c] = ~press[r][c];
        tick();
        if (newkey === 1'b1) begin
          checks++;
          if (keycode[2:0] > 3'd5) begin
            errors++;
            $display("FAIL random_col_range: got column %0d expected 0..5", keycode[2:0]);
          end
        end
      end
      release_all();
      repeat (gap) tick();
    end
    repeat (2 + DB + 4 * ST) tick();
  endtask

  initial begin
    release_all();
    test_reset();
    test_single_key();
    test_glitch();
    test_two_columns();
    test_release_bounce();
    test_reset_in_debounce();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kp_scan.md
KP_SCAN -- requirements
Module: kp_scan

Interface
REQ-001 The block SHALL have the parameter SCAN_TICKS, default 1000: clock cycles each row is driven before columns are sampled (200 us at 5 MHz).
REQ-002 The block SHALL have the parameter DB_TICKS, default 50000: consecutive stable cycles required for press and release debounce (10 ms at 5 MHz).
REQ-003 The block SHALL have port clk, input, 1 bit: 5 MHz system clock; one clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port kpcol, input, 6 bits: keypad column lines, active low, asynchronous to clk.
REQ-006 The block SHALL have port kprow, output, 4 bits: keypad row drives, active low, exactly one bit low at all times.
REQ-007 The block SHALL have port newkey, output, 1 bit: one-cycle pulse, keycode valid.
REQ-008 The block SHALL have port keycode, output, 5 bits: {row index[1:0], column index[2:0]} of the accepted key.

Function
REQ-009 kpcol SHALL pass through a two-flop synchronizer; "scol" below is the second-flop output, i.e. kpcol delayed 2 cycles.
REQ-010 The FSM SHALL have exactly three states: SCAN, DEBOUNCE and HELD.
REQ-011 The row index r (0..3) SHALL drive kprow = ~(4'b0001 << r).
REQ-012 SCAN: tick counter 0..SCAN_TICKS-1. On the last tick, scol SHALL be evaluated.
- Exactly one bit low: latch pattern and row, clear counter, go DEBOUNCE with r unchanged.
- Otherwise (none, or two or more bits low): r SHALL advance (3 wraps to 0) and the counter restarts.
REQ-013 DEBOUNCE: kprow held. Each cycle scol equals the latched pattern, the counter SHALL increment.
- On the cycle the counter reaches DB_TICKS-1 with a match: keycode SHALL load {r, column index of the low bit} and newkey SHALL be 1 on the following cycle; then go HELD.
- Any mismatch: no output change; return to SCAN with r advanced.
REQ-014 newkey SHALL be high for exactly one clk cycle per accepted press, and keycode SHALL be stable on that cycle.
REQ-015 keycode SHALL hold its value until the next accepted press.
REQ-016 HELD: kprow held. The counter counts consecutive cycles with scol == 6'b111111, and any low bit SHALL clear it.
- On reaching DB_TICKS: go SCAN with r advanced and the counter cleared.
- No further newkey SHALL occur while the key is held, however long.
REQ-017 Valid keycode column field SHALL be 0..5 only; values 6 and 7 SHALL never be produced.
REQ-018 A press shorter than DB_TICKS cycles SHALL produce no newkey.
REQ-019 Bounce during release, i.e. any low within DB_TICKS, SHALL restart the release count with no new pulse.
REQ-020 Counters SHALL be sized from the parameters (clog2) and SHALL never wrap inside a state.
REQ-021 Worst-case press-to-newkey latency SHALL be 4*SCAN_TICKS + DB_TICKS + 3 cycles.

Reset
REQ-022 While rst is high on a clock edge, the next state SHALL be:
- FSM state SCAN, r = 0, kprow = 4'b1110
- newkey = 0, keycode = 5'd0
- all counters 0, synchronizer flops 6'b111111
REQ-023 rst asserted mid-DEBOUNCE or mid-HELD SHALL abandon the press with no newkey pulse; a key still held after reset SHALL be re-detected and debounced as a fresh press.

Verification (SCAN_TICKS=4, DB_TICKS=8)
REQ-024 Bench SHALL cover the following directed scenarios:
- Reset release, no keys -> kprow sequence 1110,1101,1011,0111,1110 each for 4 cycles; newkey never 1; keycode 0.
- Key row 2, column 3: kpcol=6'b110111 while kprow==1011, held 40 cycles -> exactly one newkey pulse, keycode=5'b10011; kprow stays 1011 until 8 released cycles after release.
- 5-cycle glitch on column 0, row 0 -> no newkey; scanning resumes at row 1.
- Two columns low (6'b111100) on row 1 -> no newkey; rows keep advancing.
- Held key with release bounce (high 3, low 1, high 10) -> one newkey only; SCAN resumes only after the 8-cycle clean high run.
- rst pulsed on the 4th DEBOUNCE cycle -> no newkey; kprow=1110 the cycle after; key still held -> one newkey after fresh debounce.
